// File: rtl/burst_tick_pkg.sv
// Shared types and constants for the burst tick controller and its 9-bit counter.
// The optional PWM output is enabled by defining BURST_TICK_CTRL_PWM_EN.
package burst_tick_pkg;

    localparam int PW = 9;
    localparam int BW = 8;
    localparam logic [PW-1:0] CNT_MAX = 9'd511;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Counting up from ~period_m1 reaches CNT_MAX after exactly period_m1+1 cycles.
    function automatic logic [PW-1:0] reload_val(input logic [PW-1:0] period_m1);
        return ~period_m1;
    endfunction

endpackage

// File: rtl/cnt9_load.sv
// 9-bit loadable up-counter with terminal-count flag; load has priority over enable.
module cnt9_load
    import burst_tick_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          en,
    input  logic [PW-1:0] d,
    output logic [PW-1:0] q,
    output logic          tc
);

    logic [PW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ld) begin
            cnt_q <= d;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q  = cnt_q;
    assign tc = (cnt_q == CNT_MAX);

endmodule

// File: rtl/burst_tick_ctrl.sv
// Burst tick controller: latches period/burst on start, sequences cnt9_load, emits tick/done.
// Defining BURST_TICK_CTRL_PWM_EN adds the duty input and pwm_out output.
module burst_tick_ctrl
    import burst_tick_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [PW-1:0] period_m1,
    input  logic [BW-1:0] burst_len,
`ifdef BURST_TICK_CTRL_PWM_EN
    input  logic [PW-1:0] duty,
`endif
    output logic          busy,
    output logic          tick,
    output logic          done,
    output logic [PW-1:0] cnt,
`ifdef BURST_TICK_CTRL_PWM_EN
    output logic          pwm_out,
`endif
    output logic [1:0]    dbg_state_o
);

    state_e        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [BW-1:0] remaining_q, remaining_d;
    logic          cnt_ld, cnt_en, cnt_tc;
    logic          finite, last_tick;

    cnt9_load u_cnt (
        .clk (clk),
        .rst (rst),
        .ld  (cnt_ld),
        .en  (cnt_en),
        .d   (reload_val(period_q)),
        .q   (cnt),
        .tc  (cnt_tc)
    );

    assign finite    = (burst_q != '0);
    assign last_tick = cnt_tc && finite && (remaining_q == 8'd1);

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        burst_d     = burst_q;
        remaining_d = remaining_q;
        cnt_ld      = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    period_d = period_m1;
                    burst_d  = burst_len;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_ld      = 1'b1;
                    remaining_d = burst_q;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                // A stop wins over both reload and DONE; the counter simply freezes.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_tc) begin
                    if (finite && remaining_q != '0) begin
                        remaining_d = remaining_q - 1'b1;
                    end
                    if (last_tick) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_ld = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            burst_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            burst_q     <= burst_d;
            remaining_q <= remaining_d;
        end
    end

    assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign tick        = (state_q == ST_RUN) && cnt_tc;
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

`ifdef BURST_TICK_CTRL_PWM_EN
    logic [PW-1:0] duty_q;
    logic [PW:0]   pwm_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
        end else if (state_q == ST_IDLE && start && !stop) begin
            duty_q <= duty;
        end
    end

    // High for the last duty_q cycles of each period, tc cycle included.
    assign pwm_sum = {1'b0, cnt} + {1'b0, duty_q};
    assign pwm_out = (state_q == ST_RUN) && (pwm_sum >= 10'd512);
`endif

endmodule

// File: tb/tb_burst_tick_ctrl.sv
// Scoreboard bench for burst_tick_ctrl; tick/done events are matched against an expected queue.
module tb_burst_tick_ctrl;

    localparam int W = 27;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [8:0] period_m1;
    logic [7:0] burst_len;
    logic [8:0] duty;
    logic       busy;
    logic       tick;
    logic       done;
    logic [8:0] cnt;
    logic       pwm_out;
    logic [1:0] dbg_state_o;

    logic [W-1:0] exp_q[$];
    int           edge_cnt;
    int           checks;
    int           errors;

    burst_tick_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .period_m1   (period_m1),
        .burst_len   (burst_len),
`ifdef BURST_TICK_CTRL_PWM_EN
        .duty        (duty),
`endif
        .busy        (busy),
        .tick        (tick),
        .done        (done),
        .cnt         (cnt),
`ifdef BURST_TICK_CTRL_PWM_EN
        .pwm_out     (pwm_out),
`endif
        .dbg_state_o (dbg_state_o)
    );

`ifndef BURST_TICK_CTRL_PWM_EN
    assign pwm_out = 1'b0;
`endif

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Event encoding: {cycle, done, tick, cnt}
    function automatic logic [W-1:0] ev(input int cyc, input logic d, input logic t);
        logic [15:0] c16;
        c16 = cyc[15:0];
        return {c16, d, t, 9'd511};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, req, edge_cnt + 1);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (edge_cnt + 1 < n) @(negedge clk);
    endtask

    // Driver: returns at the negedge of cycle k+1 (LOAD) where k is the sampling edge.
    task automatic do_start(input logic [8:0] pm1, input logic [7:0] bl, input logic [8:0] du,
                            output int k);
        @(negedge clk);
        period_m1 = pm1;
        burst_len = bl;
        duty      = du;
        start     = 1'b1;
        stop      = 1'b0;
        k         = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_load", busy, 1);
    endtask

    // Monitor: pops one expectation per presented tick/done.
    task automatic run_monitor();
        logic [W-1:0] got;
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (tick || done) begin
                got = {edge_cnt[15:0] + 16'd1, done, tick, cnt};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got=%h expected=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL event got=%h expected=%h", got, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int k;
        int c;
        logic [8:0] duties [3];
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        period_m1 = '0;
        burst_len = '0;
        duty      = '0;
        fork
            run_monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_state", dbg_state_o, 0);
        rst = 1'b0;

        // P=4, burst 2
        do_start(9'd3, 8'd2, 9'd0, k);
        exp_q.push_back(ev(k + 5, 0, 1));
        exp_q.push_back(ev(k + 9, 0, 1));
        exp_q.push_back(ev(k + 10, 1, 0));
        wait_cyc(k + 2);
        chk("first_run_cnt", cnt, 508);
        wait_cyc(k + 4);
        chk("cnt_before_tc", cnt, 510);
        wait_cyc(k + 10);
        chk("busy_in_done", busy, 0);
        wait_cyc(k + 11);
        chk("idle_after_done", dbg_state_o, 0);

        // P=1, burst 4
        do_start(9'd0, 8'd4, 9'd0, k);
        for (int i = 0; i < 4; i++) exp_q.push_back(ev(k + 2 + i, 0, 1));
        exp_q.push_back(ev(k + 6, 1, 0));
        wait_cyc(k + 7);
        chk("p1_idle_busy", busy, 0);
        chk("p1_idle_state", dbg_state_o, 0);

        // P=512 continuous, ignored start and period change, then stop mid-period
        do_start(9'd511, 8'd0, 9'd0, k);
        exp_q.push_back(ev(k + 513, 0, 1));
        exp_q.push_back(ev(k + 1025, 0, 1));
        wait_cyc(k + 2);
        chk("p512_first_cnt", cnt, 0);
        wait_cyc(k + 50);
        period_m1 = 9'd5;
        burst_len = 8'd1;
        wait_cyc(k + 300);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", busy, 1);
        wait_cyc(k + 1125);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_cnt_frozen", cnt, 99);
        repeat (4) @(negedge clk);
        chk("stop_cnt_still", cnt, 99);
        chk("stop_state", dbg_state_o, 0);

        // Stop together with the final tick of burst 1
        do_start(9'd2, 8'd1, 9'd0, k);
        exp_q.push_back(ev(k + 4, 0, 1));
        wait_cyc(k + 4);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_final_busy", busy, 0);
        chk("stop_final_state", dbg_state_o, 0);
        repeat (4) @(negedge clk);

        // Start and stop together in IDLE
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_busy", busy, 0);
        chk("start_stop_state", dbg_state_o, 0);
        repeat (3) @(negedge clk);
        chk("start_stop_later", busy, 0);

        // Reset mid-burst
        do_start(9'd3, 8'd5, 9'd0, k);
        exp_q.push_back(ev(k + 5, 0, 1));
        wait_cyc(k + 7);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_tick", tick, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cnt", cnt, 0);
        chk("midrst_state", dbg_state_o, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifdef BURST_TICK_CTRL_PWM_EN
        // P=10 with duty 3, 0, 10: RUN spans cycles k+2..k+11
        duties[0] = 9'd3;
        duties[1] = 9'd0;
        duties[2] = 9'd10;
        for (int d = 0; d < 3; d++) begin
            do_start(9'd9, 8'd1, duties[d], k);
            exp_q.push_back(ev(k + 11, 0, 1));
            exp_q.push_back(ev(k + 12, 1, 0));
            chk("pwm_load_low", pwm_out, 0);
            for (c = k + 2; c <= k + 11; c++) begin
                wait_cyc(c);
                if (d == 0)      chk("pwm_duty3", pwm_out, (c >= k + 9) ? 1 : 0);
                else if (d == 1) chk("pwm_duty0", pwm_out, 0);
                else             chk("pwm_duty10", pwm_out, 1);
            end
            wait_cyc(k + 12);
            chk("pwm_done_low", pwm_out, 0);
            repeat (2) @(negedge clk);
        end
`else
        duties[0] = 9'd0;
        c = 0;
        chk("pwm_absent_low", pwm_out, {23'd0, duties[0]});
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
